// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master memory arbiter: FSM states,
// master identifiers and the wait-state counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the master that was not granted last time.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = M0;
    if (req0 && req1) begin
      gnt_id = (last_grant == M0) ? M1 : M0;
    end else if (req1) begin
      gnt_id = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises single-word accesses from two masters onto one external
// memory port, one IDLE -> BUSY (1+WAIT_STATES) -> ACK pass per access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_adr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_ack,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_adr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_writedata,
  output logic             mem_memwrite,
  output logic             mem_memread,
  input  logic [WIDTH-1:0] mem_data
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  state_t             state_reg, state_next;
  logic               last_grant_reg, last_grant_next;
  logic               owner_reg, owner_next;
  logic               we_reg, we_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   adr_reg, adr_next;
  logic [WIDTH-1:0]   wdata_reg, wdata_next;
  logic               memwrite_reg, memwrite_next;
  logic               memread_reg, memread_next;
  logic               ack0_reg, ack0_next;
  logic               ack1_reg, ack1_next;
  logic [WIDTH-1:0]   rdata0_reg, rdata0_next;
  logic [WIDTH-1:0]   rdata1_reg, rdata1_next;

  logic               gnt_valid;
  logic               gnt_id;
  logic               sel_we;
  logic [WIDTH-1:0]   sel_adr;
  logic [WIDTH-1:0]   sel_wdata;

  rr_arbiter2 u_rr (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant_reg),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign sel_we    = (gnt_id == M1) ? m1_we    : m0_we;
  assign sel_adr   = (gnt_id == M1) ? m1_adr   : m0_adr;
  assign sel_wdata = (gnt_id == M1) ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= M1;
      owner_reg      <= M0;
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      adr_reg        <= '0;
      wdata_reg      <= '0;
      memwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      we_reg         <= we_next;
      cnt_reg        <= cnt_next;
      adr_reg        <= adr_next;
      wdata_reg      <= wdata_next;
      memwrite_reg   <= memwrite_next;
      memread_reg    <= memread_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      rdata0_reg     <= rdata0_next;
      rdata1_reg     <= rdata1_next;
    end
  end

  // Strobes are computed one cycle ahead so they line up with the BUSY
  // cycle they belong to while still coming straight from flops.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    we_next         = we_reg;
    cnt_next        = cnt_reg;
    adr_next        = adr_reg;
    wdata_next      = wdata_reg;
    memwrite_next   = 1'b0;
    memread_next    = 1'b0;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    rdata0_next     = rdata0_reg;
    rdata1_next     = rdata1_reg;

    unique case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          owner_next      = gnt_id;
          last_grant_next = gnt_id;
          we_next         = sel_we;
          adr_next        = sel_adr;
          wdata_next      = sel_wdata;
          cnt_next        = WAIT_CNT;
          memread_next    = !sel_we;
          memwrite_next   = sel_we && (WAIT_CNT == '0);
          state_next      = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          state_next = ACK;
          if (owner_reg == M0) begin
            ack0_next = 1'b1;
            if (!we_reg) rdata0_next = mem_data;
          end else begin
            ack1_next = 1'b1;
            if (!we_reg) rdata1_next = mem_data;
          end
        end else begin
          cnt_next      = cnt_reg - 1'b1;
          memread_next  = !we_reg;
          memwrite_next = we_reg && (cnt_reg == CNT_W'(1));
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_adr       = adr_reg;
  assign mem_writedata = wdata_reg;
  assign mem_memwrite  = memwrite_reg;
  assign mem_memread   = memread_reg;
  assign m0_ack        = ack0_reg;
  assign m1_ack        = ack1_reg;
  assign m0_rdata      = rdata0_reg;
  assign m1_rdata      = rdata1_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with no wait states, one with three,
// each on its own word memory, checked against a reference memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]  req   [2];
  logic [1:0]  we_s  [2];
  logic [31:0] adr   [2][2];
  logic [31:0] wdata [2][2];
  wire  [1:0]  ack   [2];
  wire  [31:0] rdata [2][2];
  wire  [31:0] mem_adr  [2];
  wire  [31:0] mem_wd   [2];
  wire  [31:0] mem_data [2];
  wire  [1:0]  mem_wr;
  wire  [1:0]  mem_rd;

  logic [31:0] mem     [2][256];
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rd [2][2];
  bit          mem_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int k, input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ ((k != 0) ? 32'h5A5A_0000 : 32'h0000_A5A5);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(.WIDTH(32), .WAIT_STATES(gi * 3)) dut (
      .clk           (clk),
      .reset         (rst_n),
      .m0_req        (req[gi][0]),
      .m0_we         (we_s[gi][0]),
      .m0_adr        (adr[gi][0]),
      .m0_wdata      (wdata[gi][0]),
      .m0_ack        (ack[gi][0]),
      .m0_rdata      (rdata[gi][0]),
      .m1_req        (req[gi][1]),
      .m1_we         (we_s[gi][1]),
      .m1_adr        (adr[gi][1]),
      .m1_wdata      (wdata[gi][1]),
      .m1_ack        (ack[gi][1]),
      .m1_rdata      (rdata[gi][1]),
      .mem_adr       (mem_adr[gi]),
      .mem_writedata (mem_wd[gi]),
      .mem_memwrite  (mem_wr[gi]),
      .mem_memread   (mem_rd[gi]),
      .mem_data      (mem_data[gi])
    );
    assign mem_data[gi] = mem[gi][mem_adr[gi][9:2]];
  end

  // Word memories: filled on the first edge, then written on memwrite.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) mem[k][i] <= pat(k, i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_wr[0]) mem[0][mem_adr[0][9:2]] <= mem_wd[0];
      if (mem_wr[1]) mem[1][mem_adr[1][9:2]] <= mem_wd[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance k by master m, starting from an IDLE cycle.
  // Expected timing: 1+ws BUSY cycles then one ACK cycle.
  task automatic access(input int k, input int m, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] chg);
    int ws;
    logic [31:0] exp_rd;
    ws = 3 * k;
    exp_rd = ref_mem[k][a[9:2]];
    req[k][m] = 1'b1; we_s[k][m] = w; adr[k][m] = a; wdata[k][m] = d;
    for (int n = 1; n <= ws + 2; n++) begin
      @(posedge clk); #1;
      if (n == 1) adr[k][m] = chg;
      if (n <= ws + 1) begin
        check("busy_adr", mem_adr[k], a);
        if (w) check("busy_wdata", mem_wd[k], d);
        check("busy_wr", 32'(mem_wr[k]), 32'(w && (n == ws + 1)));
        check("busy_rd", 32'(mem_rd[k]), 32'(!w));
        check("busy_ack", 32'(ack[k]), 32'd0);
      end else begin
        check("ack", 32'(ack[k]), (m == 0) ? 32'd1 : 32'd2);
        check("ack_wr", 32'(mem_wr[k]), 32'd0);
        check("ack_rd", 32'(mem_rd[k]), 32'd0);
        if (!w) check("rdata", rdata[k][m], exp_rd);
      end
    end
    if (w) ref_mem[k][a[9:2]] = d;
    else   last_rd[k][m] = exp_rd;
    $display("access dut%0d m%0d %s adr=%h data=%h", k, m, w ? "wr" : "rd", a, w ? d : exp_rd);
    req[k][m] = 1'b0;
    @(posedge clk); #1;
    check("idle_ack", 32'(ack[k]), 32'd0);
    check("hold_rdata0", rdata[k][0], last_rd[k][0]);
    check("hold_rdata1", rdata[k][1], last_rd[k][1]);
  endtask

  initial begin
    int id, n_ack, k, m;
    bit w, got;
    logic [31:0] a, d;

    rst_n = 1'b0;
    for (int kk = 0; kk < 2; kk++) begin
      req[kk] = 2'b00; we_s[kk] = 2'b00;
      for (int mm = 0; mm < 2; mm++) begin
        adr[kk][mm] = '0; wdata[kk][mm] = '0; last_rd[kk][mm] = '0;
      end
      for (int i = 0; i < 256; i++) ref_mem[kk][i] = pat(kk, i);
    end

    // Reset with a pending m0 read
    req[0][0] = 1'b1; adr[0][0] = 32'h14;
    repeat (3) @(posedge clk);
    #1;
    for (int kk = 0; kk < 2; kk++) begin
      check("rst_mem_adr", mem_adr[kk], 32'd0);
      check("rst_mem_wd", mem_wd[kk], 32'd0);
      check("rst_mem_wr", 32'(mem_wr[kk]), 32'd0);
      check("rst_mem_rd", 32'(mem_rd[kk]), 32'd0);
      check("rst_ack", 32'(ack[kk]), 32'd0);
      check("rst_rdata0", rdata[kk][0], 32'd0);
      check("rst_rdata1", rdata[kk][1], 32'd0);
    end
    rst_n = 1'b1;
    access(0, 0, 0, 32'h14, 32'h0, 32'h14);

    // m1 writes, m0 reads the same word back
    access(0, 1, 1, 32'h20, 32'h7, 32'h20);
    access(0, 0, 0, 32'h20, 32'h0, 32'h20);
    check("readback_7", rdata[0][0], 32'h7);

    // Both masters requesting continuously from reset
    rst_n = 1'b0;
    req[0] = 2'b11; we_s[0] = 2'b00; adr[0][0] = 32'h8; adr[0][1] = 32'hC;
    for (int kk = 0; kk < 2; kk++) begin last_rd[kk][0] = '0; last_rd[kk][1] = '0; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_ack = 0;
    for (int c = 1; c <= 30 && n_ack < 6; c++) begin
      @(posedge clk); #1;
      if (ack[0] != 2'b00) begin
        id = (ack[0] == 2'b01) ? 0 : (ack[0] == 2'b10) ? 1 : 3;
        $display("rr ack %0d: master %0d at cycle %0d", n_ack, id, c);
        check("rr_order", 32'(id), 32'(n_ack % 2));
        check("rr_cycle", 32'(c), 32'(2 + 3 * n_ack));
        if (id < 2) begin
          check("rr_rdata", rdata[0][id], ref_mem[0][adr[0][id][9:2]]);
          last_rd[0][id] = ref_mem[0][adr[0][id][9:2]];
        end
        n_ack++;
        if (n_ack == 6) req[0] = 2'b00;
      end
    end
    check("rr_count", 32'(n_ack), 32'd6);
    @(posedge clk); #1;

    // Random single accesses on both instances
    for (int t = 0; t < 24; t++) begin
      k = t % 2;
      m = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      access(k, m, w, a, d, a);
    end

    // Wait-state write, then request fields changed during BUSY
    access(1, 0, 1, 32'h100, 32'hCAFE_F00D, 32'h100);
    access(1, 0, 0, 32'h10, 32'h0, 32'h30);
    access(0, 0, 0, 32'h10, 32'h0, 32'h30);

    // Reset in the second BUSY cycle of a wait-state write
    req[1][0] = 1'b1; we_s[1][0] = 1'b1; adr[1][0] = 32'h40; wdata[1][0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_wr", 32'(mem_wr[1]), 32'd0);
    check("abort_ack", 32'(ack[1]), 32'd0);
    req[1] = 2'b11; we_s[1] = 2'b00; adr[1][0] = 32'h44; adr[1][1] = 32'h48;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_wr_hold", 32'(mem_wr[1]), 32'd0);
      check("abort_ack_hold", 32'(ack[1]), 32'd0);
    end
    for (int kk = 0; kk < 2; kk++) begin last_rd[kk][0] = '0; last_rd[kk][1] = '0; end
    rst_n = 1'b1;
    check("abort_no_write", mem[1][16], ref_mem[1][16]);
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      check("abort_no_write_late", 32'(mem_wr[1]), 32'd0);
      if (ack[1] != 2'b00) begin
        got = 1'b1;
        $display("post-reset tie: ack=%b at cycle %0d", ack[1], c);
        check("tie_m0", 32'(ack[1]), 32'd1);
        check("tie_cycle", 32'(c), 32'd5);
        check("tie_rdata", rdata[1][0], ref_mem[1][32'h44 >> 2]);
        req[1] = 2'b00;
      end
    end
    check("tie_seen", 32'(got), 32'd1);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
